// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes NUM_SRC request lines, latches them as pending and
// presents one request to the CPU, serviced through a claim/complete register handshake.
module irq_ctrl #(
   parameter int                 NUM_SRC  = 8,
   parameter logic [NUM_SRC-1:0] EDGE_RST = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic               sel,
   input  logic               we,
   input  logic [3:0]         addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               irq_out
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] SERVICE = 1'b1;

   localparam logic [3:0] ADDR_PENDING = 4'h0;
   localparam logic [3:0] ADDR_ENABLE  = 4'h4;
   localparam logic [3:0] ADDR_CLAIM   = 4'h8;
   localparam logic [3:0] ADDR_EDGE    = 4'hC;

   logic [NUM_SRC-1:0] s1, s2, s3;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] enable;
   logic [NUM_SRC-1:0] edge_mode;
   logic [0:0]         state;
   logic [4:0]         cur_id;

   logic               rd_acc;
   logic               wr_acc;
   logic [NUM_SRC-1:0] active;
   logic [NUM_SRC-1:0] set_req;
   logic [NUM_SRC-1:0] blocked;
   logic [NUM_SRC-1:0] w1c_mask;
   logic [NUM_SRC-1:0] claim_mask;
   logic [4:0]         claim_id;
   logic               claim;
   logic               complete;
   logic [31:0]        rd_mux;
   logic               unused_wdata;

   // Lowest index wins, so scan from the top and let lower indices overwrite.
   function automatic logic [4:0] lowest_id(input logic [NUM_SRC-1:0] req);
      logic [4:0] id;
      id = 5'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) id = 5'(i + 1);
      end
      return id;
   endfunction

   function automatic logic [NUM_SRC-1:0] id_mask(input logic [4:0] id);
      logic [NUM_SRC-1:0] m;
      for (int i = 0; i < NUM_SRC; i++) begin
         m[i] = (id == 5'(i + 1));
      end
      return m;
   endfunction

   assign rd_acc   = sel & ~we;
   assign wr_acc   = sel & we;
   assign active   = pending & enable;
   assign claim_id = lowest_id(active);

   assign claim    = rd_acc && (addr == ADDR_CLAIM) && (state == IDLE) && (claim_id != 5'd0);
   assign complete = wr_acc && (addr == ADDR_CLAIM) && (state == SERVICE) && (wdata[4:0] == cur_id);

   assign claim_mask = claim ? id_mask(claim_id) : '0;
   assign blocked    = (state == SERVICE) ? id_mask(cur_id) : '0;
   assign w1c_mask   = (wr_acc && (addr == ADDR_PENDING)) ? wdata[NUM_SRC-1:0] : '0;

   // The claimed source cannot re-pend until its complete has been accepted.
   assign set_req = ((edge_mode & s2 & ~s3) | (~edge_mode & s2)) & ~blocked;

   assign irq_out      = (state == IDLE) && (|active);
   assign unused_wdata = ^wdata;

   always_comb begin
      rd_mux = 32'd0;
      case (addr)
         ADDR_PENDING: rd_mux = 32'(pending);
         ADDR_ENABLE:  rd_mux = 32'(enable);
         ADDR_CLAIM:   rd_mux = (state == IDLE) ? 32'(claim_id) : 32'd0;
         ADDR_EDGE:    rd_mux = 32'(edge_mode);
         default:      rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= src_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Set beats a same-cycle W1C; a claim clear beats a same-cycle set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
      end else begin
         pending <= ((pending & ~w1c_mask) | set_req) & ~claim_mask;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable    <= '0;
         edge_mode <= EDGE_RST;
      end else if (wr_acc) begin
         if (addr == ADDR_ENABLE) enable <= wdata[NUM_SRC-1:0];
         if (addr == ADDR_EDGE)   edge_mode <= wdata[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cur_id <= 5'd0;
      end else if (claim) begin
         state  <= SERVICE;
         cur_id <= claim_id;
      end else if (complete) begin
         state  <= IDLE;
         cur_id <= 5'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= 32'd0;
      end else if (rd_acc) begin
         rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed register/source sequences, a reference model of the
// controller's rules checked every cycle, plus literal expectations at key points.
module tb_irq_ctrl;

   localparam int         N           = 8;
   localparam logic [7:0] EDGE_RST_TB = 8'h10;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] src_in = '0;
   logic         sel = 1'b0;
   logic         we = 1'b0;
   logic [3:0]   addr = 4'h0;
   logic [31:0]  wdata = 32'd0;
   logic [31:0]  rdata;
   logic         irq_out;

   int checks = 0;
   int errors = 0;

   irq_ctrl #(.NUM_SRC(N), .EDGE_RST(EDGE_RST_TB)) dut (
      .clk     (clk),
      .reset   (reset),
      .src_in  (src_in),
      .sel     (sel),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq_out (irq_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: source history per clock edge plus the architectural registers.
   logic [N-1:0] src_log [0:4095];
   int           cyc;
   logic [N-1:0] m_pend, m_en, m_edge;
   logic         m_busy;
   int           m_cur;
   logic [31:0]  m_rdata;

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            cyc = 0; m_pend = '0; m_en = '0; m_edge = EDGE_RST_TB;
            m_busy = 1'b0; m_cur = 0; m_rdata = 32'd0;
         end else begin
            logic [N-1:0] lvl, prv, setv, w1c, clr;
            int id;
            lvl = (cyc >= 2) ? src_log[(cyc - 2) % 4096] : '0;
            prv = (cyc >= 3) ? src_log[(cyc - 3) % 4096] : '0;
            src_log[cyc % 4096] = src_in;
            cyc++;
            for (int i = 0; i < N; i++) begin
               setv[i] = m_edge[i] ? (lvl[i] & ~prv[i]) : lvl[i];
               if (m_busy && m_cur == i + 1) setv[i] = 1'b0;
            end
            id = 0;
            for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) id = i + 1;
            w1c = '0;
            clr = '0;
            if (sel && !we) begin
               case (addr)
                  4'h0: m_rdata = 32'(m_pend);
                  4'h4: m_rdata = 32'(m_en);
                  4'hC: m_rdata = 32'(m_edge);
                  4'h8: begin
                     if (m_busy) m_rdata = 32'd0;
                     else begin
                        m_rdata = 32'(id);
                        if (id != 0) begin
                           clr[id-1] = 1'b1;
                           m_busy = 1'b1;
                           m_cur = id;
                        end
                     end
                  end
                  default: m_rdata = 32'd0;
               endcase
            end else if (sel && we) begin
               case (addr)
                  4'h0: w1c = wdata[N-1:0];
                  4'h4: m_en = wdata[N-1:0];
                  4'hC: m_edge = wdata[N-1:0];
                  4'h8: if (m_busy && int'(wdata[4:0]) == m_cur) begin
                     m_busy = 1'b0;
                     m_cur = 0;
                  end
                  default: ;
               endcase
            end
            m_pend = ((m_pend & ~w1c) | setv) & ~clr;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            check("model_irq_out", 32'(irq_out), 32'((!m_busy) && (|(m_pend & m_en))));
            check("model_rdata", rdata, m_rdata);
         end
      end
   end

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      sel = 1'b0;
      d = rdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      reset = 1'b1;
      #3 reset = 1'b0;
      #1;
      check("reset_irq_out", 32'(irq_out), 32'd0);
      check("reset_rdata", rdata, 32'd0);
      idle(2);
      reset = 1'b1;

      bus_read(4'hC, d);  check("edge_reset_value", d, 32'h10);
      bus_read(4'h0, d);  check("pending_reset", d, 32'h0);
      bus_read(4'h8, d);  check("claim_nothing", d, 32'h0);
      check("claim_nothing_irq", 32'(irq_out), 32'd0);
      bus_read(4'h6, d);  check("unmapped_read", d, 32'h0);

      // Level timer: 3-cycle latency, claim, complete while still high re-raises.
      bus_write(4'h4, 32'h1);
      @(negedge clk); src_in = 8'h01;
      @(negedge clk); check("lat_k", 32'(irq_out), 32'd0);
      @(negedge clk); check("lat_k1", 32'(irq_out), 32'd0);
      @(negedge clk); check("lat_k2", 32'(irq_out), 32'd1);
      bus_read(4'h8, d);  check("claim_level", d, 32'h1);
      check("claim_drops_irq", 32'(irq_out), 32'd0);
      bus_write(4'h8, 32'h1);
      check("complete_irq_c1", 32'(irq_out), 32'd0);
      @(negedge clk); check("complete_irq_c2", 32'(irq_out), 32'd1);
      src_in = 8'h00;
      idle(3);
      bus_read(4'h8, d);  check("claim_level_again", d, 32'h1);
      bus_write(4'h8, 32'h1);

      // Priority plus handshake errors.
      bus_write(4'h4, 32'h6);
      @(negedge clk); src_in = 8'h06;
      idle(2); src_in = 8'h00;
      idle(4);
      bus_read(4'h0, d);  check("prio_pending", d, 32'h6);
      bus_read(4'h8, d);  check("prio_claim_2", d, 32'h2);
      bus_write(4'h8, 32'h5);
      check("wrong_id_irq", 32'(irq_out), 32'd0);
      bus_read(4'h8, d);  check("claim_in_service", d, 32'h0);
      bus_write(4'h8, 32'h2);
      check("after_complete_irq", 32'(irq_out), 32'd1);
      bus_read(4'h8, d);  check("prio_claim_3", d, 32'h3);
      bus_write(4'h8, 32'h3);
      bus_read(4'h0, d);  check("prio_pending_empty", d, 32'h0);

      // Edge mode: single-cycle pulses, one record while pending, W1C.
      bus_write(4'h4, 32'h0);
      bus_write(4'hC, 32'h2);
      @(negedge clk); src_in = 8'h02;
      @(negedge clk); src_in = 8'h00;
      idle(4);
      bus_read(4'h0, d);  check("edge_pulse1", d, 32'h2);
      @(negedge clk); src_in = 8'h02;
      @(negedge clk); src_in = 8'h00;
      idle(4);
      bus_read(4'h0, d);  check("edge_pulse2", d, 32'h2);
      bus_write(4'h0, 32'h2);
      bus_read(4'h0, d);  check("edge_w1c", d, 32'h0);
      @(negedge clk); src_in = 8'h02;
      idle(5);
      bus_write(4'h0, 32'h2);
      bus_read(4'h0, d);  check("edge_held_once", d, 32'h0);
      src_in = 8'h00;
      bus_read(4'hC, d);  check("edge_readback", d, 32'h2);
      bus_write(4'hC, 32'hFFFF_FF00);
      bus_read(4'hC, d);  check("edge_upper_ignored", d, 32'h0);

      // Set beats W1C; disabling keeps pending.
      @(negedge clk); src_in = 8'h01;
      idle(4);
      bus_write(4'h0, 32'h1);
      bus_read(4'h0, d);  check("set_beats_w1c", d, 32'h1);
      bus_write(4'h4, 32'h1);
      check("enabled_irq", 32'(irq_out), 32'd1);
      bus_write(4'h4, 32'h0);
      check("disabled_irq", 32'(irq_out), 32'd0);
      bus_read(4'h0, d);  check("disabled_keeps_pending", d, 32'h1);
      bus_write(4'h4, 32'h1);
      check("reenabled_irq", 32'(irq_out), 32'd1);
      src_in = 8'h00;
      idle(3);
      bus_write(4'h0, 32'h1);
      bus_read(4'h0, d);  check("w1c_after_drop", d, 32'h0);

      // Reset in the middle of a claim.
      bus_write(4'h4, 32'hFF);
      @(negedge clk); src_in = 8'hFF;
      idle(4);
      bus_read(4'h0, d);  check("all_pending", d, 32'hFF);
      bus_read(4'h8, d);  check("claim_before_reset", d, 32'h1);
      @(negedge clk);
      #1 reset = 1'b0; src_in = 8'h00;
      #1;
      check("async_reset_irq", 32'(irq_out), 32'd0);
      check("async_reset_rdata", rdata, 32'd0);
      idle(2);
      reset = 1'b1;
      bus_read(4'h0, d);  check("post_reset_pending", d, 32'h0);
      bus_read(4'h4, d);  check("post_reset_enable", d, 32'h0);
      bus_read(4'hC, d);  check("post_reset_edge", d, 32'h10);
      bus_read(4'h8, d);  check("post_reset_claim", d, 32'h0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
